quad_updown_decoder: RTL
========================

QUAD_UPDOWN_DECODER -- requirements
Module: quad_updown_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the position counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port a_in, input, 1 bit: quadrature channel A, asynchronous to clk.
REQ-005 The block SHALL have port b_in, input, 1 bit: quadrature channel B, asynchronous to clk.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of position and err.
REQ-007 The block SHALL have port step, output, 1 bit: one-cycle pulse per decoded legal transition.
REQ-008 The block SHALL have port up_down, output, 1 bit: direction of the last step; 1 = up, 0 = down; directly drives an up/down counter's up_down input.
REQ-009 The block SHALL have port position, output, WIDTH bits: signed-agnostic running count.
REQ-010 The block SHALL have port err, output, 1 bit: sticky illegal-transition flag.

Function
REQ-011 a_in and b_in SHALL each pass through a two-flop synchronizer; no other logic SHALL sample the raw inputs.
REQ-012 The decoder SHALL compare the current accepted {A,B} with a registered previous {A,B} every cycle.
REQ-013 Up sequence: {A,B} 00->10->11->01->00; each such transition SHALL give step=1, up_down=1, position+1.
REQ-014 Down sequence: the reverse (00->01->11->10->00); each SHALL give step=1, up_down=0, position-1.
REQ-015 No change SHALL give step=0; up_down and position SHALL hold.
REQ-016 Both bits changing in one accepted sample (00<->11, 10<->01) SHALL set err=1, give step=0, and leave position and up_down unchanged; prev SHALL still update to the new value.
REQ-017 Latency without filter: an input level stable before edge E0 SHALL be reflected in step, up_down and position after edge E2.
REQ-018 position SHALL wrap modulo 2^WIDTH: all-ones +1 -> 0, and 0 -1 -> all-ones.
REQ-019 step, up_down and position SHALL be registered outputs.
REQ-020 clr=1 SHALL force position=0 and err=0 on that edge, overriding any concurrent step or error.
REQ-021 During a clr cycle, step, up_down and prev SHALL update normally.
REQ-022 err SHALL remain 1 until clr or rst.

Reset
REQ-023 rst SHALL asynchronously force the synchronizers, prev, position, step, up_down and err to 0.
REQ-024 The first accepted sample after rst deasserts SHALL only load prev and SHALL NOT produce step or err, so inputs held at 11 through reset cause no false error.
REQ-025 Reset asserted mid-sequence SHALL discard all history; decoding SHALL restart per REQ-024.

Configuration
REQ-026 Macro QUAD_GLITCH_FILTER_EN SHALL be the only compile-time option.
REQ-027 Macro defined: a synchronized value SHALL be accepted only after three consecutive identical samples, adding 2 cycles of latency (outputs after E4); shorter pulses SHALL be ignored.
REQ-028 Macro undefined: the synchronizer output SHALL be accepted directly, and no filter logic SHALL be present.

Verification
REQ-029 rst, then drive {a,b} 00,10,11,01,00, each held 8 cycles -> four step pulses, up_down=1, position=4, err=0.
REQ-030 From position=0, drive the down sequence through 5 transitions -> position=4'hB (wraps through F), up_down=0.
REQ-031 Jump {a,b} 00->11 -> err=1, step=0, position unchanged; then pulse clr -> err=0, position=0.
REQ-032 Hold {a,b}=11 through rst release -> no step and no err; then 11->01 -> one step, up_down=1.
REQ-033 Apply clr on the same edge as a decoded step -> position=0, step=1.
REQ-034 With QUAD_GLITCH_FILTER_EN, a 2-cycle pulse on a_in -> no step; a 3-cycle-stable change -> step after E4. Without the macro, the same 2-cycle pulse -> step after E2 (up), followed by a matching down step.

Source files
------------

// File: rtl/quad_updown_decoder_if.sv
// Quadrature decoder port bundle: raw A/B channels and clear in, step/direction/position/error out.
interface quad_updown_decoder_if #(
    parameter int WIDTH = 4
);
    logic             a_in;
    logic             b_in;
    logic             clr;
    logic             step;
    logic             up_down;
    logic [WIDTH-1:0] position;
    logic             err;

    modport master (
        output a_in, b_in, clr,
        input  step, up_down, position, err
    );

    modport slave (
        input  a_in, b_in, clr,
        output step, up_down, position, err
    );
endinterface

// File: rtl/quad_updown_decoder.sv
// Quadrature A/B decoder with registered step/up_down pulses, wrapping position count and sticky err; free-running, no backpressure.
// Outputs follow an input change after 3 edges; defining QUAD_GLITCH_FILTER_EN requires 3 identical samples first (5 edges).
module quad_updown_decoder #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    quad_updown_decoder_if.slave  bus
);

    logic [1:0]       sync1, sync2;
    logic             v1, v2;
    logic [1:0]       cur;
    logic             cur_vld;
    logic [1:0]       prev;
    logic             primed;
    logic [1:0]       delta;
    logic             is_up, is_dn, is_err;
    logic             step_q, up_down_q, err_q;
    logic [WIDTH-1:0] position_q;

    // The v* bits mark which pipeline stages hold real post-reset samples, so
    // reset values of the synchronizer are never decoded against live inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            v1    <= 1'b0;
            v2    <= 1'b0;
        end else begin
            sync1 <= {bus.a_in, bus.b_in};
            sync2 <= sync1;
            v1    <= 1'b1;
            v2    <= v1;
        end
    end

`ifdef QUAD_GLITCH_FILTER_EN
    logic [1:0] f1, f2;
    logic       v3, v4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f1 <= 2'b00;
            f2 <= 2'b00;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else begin
            f1 <= sync2;
            f2 <= f1;
            v3 <= v2;
            v4 <= v3;
        end
    end

    assign cur     = sync2;
    assign cur_vld = v2 && v3 && v4 && (sync2 == f1) && (f1 == f2);
`else
    assign cur     = sync2;
    assign cur_vld = v2;
`endif

    // Map the Gray sequence 00,10,11,01 to phases 0..3 so direction is a modular difference.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b00:   phase = 2'd0;
            2'b10:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    assign delta  = phase(cur) - phase(prev);
    assign is_up  = cur_vld && primed && (delta == 2'd1);
    assign is_dn  = cur_vld && primed && (delta == 2'd3);
    assign is_err = cur_vld && primed && (delta == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= 2'b00;
            primed     <= 1'b0;
            step_q     <= 1'b0;
            up_down_q  <= 1'b0;
            position_q <= '0;
            err_q      <= 1'b0;
        end else begin
            step_q <= is_up || is_dn;
            if (is_up || is_dn)
                up_down_q <= is_up;
            if (cur_vld) begin
                prev   <= cur;
                primed <= 1'b1;
            end
            if (bus.clr) begin
                position_q <= '0;
                err_q      <= 1'b0;
            end else begin
                if (is_up)
                    position_q <= position_q + WIDTH'(1);
                else if (is_dn)
                    position_q <= position_q - WIDTH'(1);
                if (is_err)
                    err_q <= 1'b1;
            end
        end
    end

    assign bus.step     = step_q;
    assign bus.up_down  = up_down_q;
    assign bus.position = position_q;
    assign bus.err      = err_q;

endmodule
